// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared state encodings, master ids and helpers for the GPIO bus arbiter.
package gpio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam logic MST_CORE = 1'b0;
  localparam logic MST_DBG  = 1'b1;

  function automatic logic rr_other(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/gpio_arb_rr.sv
// Combinational 2-way round-robin picker; an active lock pins the grant to
// the lock owner for as long as that owner keeps requesting.
module gpio_arb_rr
  import gpio_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lock_i,
  input  logic       lock_owner_i,
  output logic       valid_o,
  output logic       winner_o
);

  // Lock first, then single requester, then the master not served last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = MST_CORE;
    if (lock_i && req_i[lock_owner_i]) begin
      valid_o  = 1'b1;
      winner_o = lock_owner_i;
    end else begin
      case (req_i)
        2'b01: begin
          valid_o  = 1'b1;
          winner_o = MST_CORE;
        end
        2'b10: begin
          valid_o  = 1'b1;
          winner_o = MST_DBG;
        end
        2'b11: begin
          valid_o  = 1'b1;
          winner_o = rr_other(last_i);
        end
        default: begin
          valid_o  = 1'b0;
          winner_o = MST_CORE;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter for the GPIO register port: IDLE -> ACCESS -> RESP.
// Optional sticky ownership is enabled by defining GPIO_ARB_LOCK_EN.
module gpio_bus_arbiter
  import gpio_bus_arbiter_pkg::*;
#(
  parameter int   ADDR_W  = 32,
  parameter int   DATA_W  = 32,
  parameter logic RR_INIT = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_lock_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_wraddr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  arb_state_e        state_q;
  logic              owner_q, last_q, cmd_we_q, s_we_q;
  logic              m0_ack_q, m1_ack_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q, m0_rdata_q, m1_rdata_q;
  logic [1:0]        req_s;
  logic              grant_valid_s, winner_s, lock_s;

  assign req_s = {m1_req_i, m0_req_i};

`ifdef GPIO_ARB_LOCK_EN
  logic lock_q;
  logic owner_lock_s;
  assign owner_lock_s = owner_q ? m1_lock_i : m0_lock_i;
  assign lock_s       = lock_q;
`else
  logic unused_lock_s;
  assign unused_lock_s = m0_lock_i ^ m1_lock_i;
  assign lock_s        = 1'b0;
`endif

  gpio_arb_rr u_rr (
    .req_i        (req_s),
    .last_i       (last_q),
    .lock_i       (lock_s),
    .lock_owner_i (owner_q),
    .valid_o      (grant_valid_s),
    .winner_o     (winner_s)
  );

  // Transaction FSM with command latches and registered responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= MST_CORE;
      last_q      <= RR_INIT;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= {ADDR_W{1'b0}};
      cmd_wdata_q <= {DATA_W{1'b0}};
      s_we_q      <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= {DATA_W{1'b0}};
      m1_rdata_q  <= {DATA_W{1'b0}};
`ifdef GPIO_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
          if (lock_q && !req_s[owner_q]) begin
            lock_q <= 1'b0;
          end
`endif
          if (grant_valid_s) begin
            owner_q     <= winner_s;
            cmd_we_q    <= winner_s ? m1_we_i    : m0_we_i;
            cmd_addr_q  <= winner_s ? m1_addr_i  : m0_addr_i;
            cmd_wdata_q <= winner_s ? m1_wdata_i : m0_wdata_i;
            s_we_q      <= winner_s ? m1_we_i    : m0_we_i;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          s_we_q <= 1'b0;
          // Writes return zero data; the non-owner's rdata is left untouched.
          if (owner_q == MST_DBG) begin
            m1_ack_q   <= 1'b1;
            m1_rdata_q <= cmd_we_q ? {DATA_W{1'b0}} : s_rdata_i;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_rdata_q <= cmd_we_q ? {DATA_W{1'b0}} : s_rdata_i;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
          if (owner_lock_s) begin
            lock_q <= 1'b1;
          end else begin
            lock_q <= 1'b0;
            last_q <= owner_q;
          end
`else
          last_q <= owner_q;
`endif
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          s_we_q   <= 1'b0;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign m0_ack_o   = m0_ack_q;
  assign m1_ack_o   = m1_ack_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;
  assign s_we_o     = s_we_q;
  assign s_wraddr_o = cmd_addr_q;
  assign s_wdata_o  = cmd_wdata_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign owner_o    = owner_q;

endmodule
